// File: rtl/stream2mtx_pkg.sv
// stream2mtx_pkg: shared FSM state encoding and width helpers for the stream-to-matrix packer.
`default_nettype none

package stream2mtx_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Width of a dimension field able to hold 0..dim inclusive.
    function automatic int dim_w(input int dim);
        return $clog2(dim) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/stream2mtx_lane_ptr.sv
// stream2mtx_lane_ptr: (x,y) matrix coordinate for one input lane, stepping by LANES with a single wrap.
`default_nettype none

module stream2mtx_lane_ptr
    import stream2mtx_pkg::*;
#(
    parameter int DIM   = 32,
    parameter int LANES = 4,
    parameter int LANE  = 0,
    localparam int DIM_W = dim_w(DIM)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             init,
    input  logic             step,
    input  logic [DIM_W-1:0] m,
    input  logic [DIM_W-1:0] n,
    output logic [DIM_W-1:0] x,
    output logic [DIM_W-1:0] y,
    output logic             valid
);

    logic [DIM_W:0]   x_sum;
    logic             wrap;
    logic [DIM_W-1:0] x_next;

    // m >= LANES guarantees x + LANES < 2*m, so one subtraction always suffices.
    always_comb begin
        x_sum  = {1'b0, x} + (DIM_W + 1)'(LANES);
        wrap   = (x_sum >= {1'b0, m});
        x_next = wrap ? DIM_W'(x_sum - {1'b0, m}) : x_sum[DIM_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x <= '0;
            y <= '0;
        end else if (init) begin
            x <= DIM_W'(LANE);
            y <= '0;
        end else if (step) begin
            x <= x_next;
            y <= wrap ? y + 1'b1 : y;
        end
    end

    assign valid = (y < n);

endmodule

`default_nettype wire

// File: rtl/stream2mtx.sv
// stream2mtx: packs a valid/ready stream of LANES-pixel words into a runtime m x n register matrix.
// Optional STREAM2MTX_CLEAR_EN: clear the whole matrix on every legal start.
`default_nettype none

module stream2mtx
    import stream2mtx_pkg::*;
#(
    parameter int BITS  = 8,
    parameter int DIM   = 32,
    parameter int LANES = 4,
    localparam int DIM_W = dim_w(DIM),
    localparam int CNT_W = 2 * DIM_W
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                start,
    input  logic [DIM_W-1:0]                    m,
    input  logic [DIM_W-1:0]                    n,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [LANES*BITS-1:0]               in_data,
    output logic [DIM-1:0][DIM-1:0][BITS-1:0]   mtx,
    output logic                                busy,
    output logic                                full,
    output logic                                err
);

    state_t           state_q, state_d;
    logic [DIM_W-1:0] m_q, n_q;
    logic [CNT_W-1:0] rem;
    logic             legal, accept, last;

    logic [BITS-1:0]  pix [LANES];
    logic [DIM_W-1:0] px  [LANES];
    logic [DIM_W-1:0] py  [LANES];
    logic [LANES-1:0] pvalid;
    logic [LANES-1:0] we;

    assign legal    = (m >= DIM_W'(LANES)) && (m <= DIM_W'(DIM)) &&
                      (n != '0) && (n <= DIM_W'(DIM));
    assign in_ready = (state_q == S_FILL);
    assign busy     = (state_q == S_FILL);
    // A beat coinciding with start belongs to the aborted fill and is dropped.
    assign accept   = in_valid && in_ready && !start;
    assign last     = accept && (rem <= CNT_W'(LANES));

    generate
        for (genvar l = 0; l < LANES; l++) begin : g_lane
            assign pix[l] = in_data[(LANES-l)*BITS-1 -: BITS];
            assign we[l]  = accept && pvalid[l] && (CNT_W'(l) < rem);

            stream2mtx_lane_ptr #(
                .DIM   (DIM),
                .LANES (LANES),
                .LANE  (l)
            ) u_ptr (
                .clk   (clk),
                .rst_n (rst_n),
                .init  (start),
                .step  (accept),
                .m     (m_q),
                .n     (n_q),
                .x     (px[l]),
                .y     (py[l]),
                .valid (pvalid[l])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) state_d = legal ? S_FILL : S_DONE;
            end
            S_FILL: begin
                if (start)     state_d = legal ? S_FILL : S_DONE;
                else if (last) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Pixel countdown: m*n is formed once per start, then decremented by LANES per beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q  <= '0;
            n_q  <= '0;
            rem  <= '0;
            full <= 1'b0;
            err  <= 1'b0;
        end else if (start) begin
            m_q  <= m;
            n_q  <= n;
            rem  <= legal ? CNT_W'(m) * CNT_W'(n) : '0;
            full <= 1'b0;
            err  <= !legal;
        end else if (accept) begin
            rem  <= last ? '0 : rem - CNT_W'(LANES);
            full <= full | last;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtx <= '0;
        end else begin
`ifdef STREAM2MTX_CLEAR_EN
            if (start && legal) mtx <= '0;
`endif
            for (int xi = 0; xi < DIM; xi++) begin
                for (int yi = 0; yi < DIM; yi++) begin
                    for (int l = 0; l < LANES; l++) begin
                        if (we[l] && (px[l] == DIM_W'(xi)) && (py[l] == DIM_W'(yi)))
                            mtx[xi][yi] <= pix[l];
                    end
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_stream2mtx.sv
// tb_stream2mtx: scoreboard bench for stream2mtx (default parameters).
`default_nettype none

module tb_stream2mtx;

    localparam int BITS  = 8;
    localparam int DIM   = 32;
    localparam int LANES = 4;
    localparam int DW    = 6;
`ifdef STREAM2MTX_CLEAR_EN
    localparam bit CLEAR = 1'b1;
`else
    localparam bit CLEAR = 1'b0;
`endif

    logic                              clk = 1'b0;
    logic                              rst_n = 1'b0;
    logic                              start = 1'b0;
    logic [DW-1:0]                     m = '0;
    logic [DW-1:0]                     n = '0;
    logic                              in_valid = 1'b0;
    logic                              in_ready;
    logic [LANES*BITS-1:0]             in_data = '0;
    logic [DIM-1:0][DIM-1:0][BITS-1:0] mtx;
    logic                              busy, full, err;

    stream2mtx #(.BITS(BITS), .DIM(DIM), .LANES(LANES)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .m        (m),
        .n        (n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .mtx      (mtx),
        .busy     (busy),
        .full     (full),
        .err      (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         x;
        int         y;
        logic [7:0] v;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] mdl [DIM][DIM];
    int         total = 0;
    int         bad = 0;
    int         cur_m = 0, cur_n = 0, npx = 0, kidx = 0;
    logic [7:0] seed = '0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic clear_model();
        for (int x = 0; x < DIM; x++)
            for (int y = 0; y < DIM; y++)
                mdl[x][y] = 8'h00;
    endtask

    task automatic check_matrix(input string tag);
        int e = 0;
        for (int x = 0; x < DIM; x++)
            for (int y = 0; y < DIM; y++)
                if (mtx[x][y] !== mdl[x][y]) e++;
        check(tag, e, 0);
    endtask

    // Entered and left at a negedge; optionally presents a beat alongside start.
    task automatic do_start(input int mm, input int nn, input bit with_beat);
        bit lg;
        lg    = (mm >= LANES) && (mm <= DIM) && (nn >= 1) && (nn <= DIM);
        start = 1'b1;
        m     = DW'(mm);
        n     = DW'(nn);
        if (with_beat) begin
            in_valid = 1'b1;
            in_data  = 32'hFFFF_FFFF;
        end
        @(posedge clk);
        #1;
        start    = 1'b0;
        in_valid = 1'b0;
        if (lg) begin
            cur_m = mm;
            cur_n = nn;
            npx   = mm * nn;
            kidx  = 0;
            if (CLEAR) clear_model();
        end
        check("busy_after_start", busy, lg);
        check("err_after_start", err, !lg);
        check("full_after_start", full, 0);
        check("ready_after_start", in_ready, lg);
        @(negedge clk);
    endtask

    task automatic send_beat(input int gap_pct);
        logic [31:0] d;
        int          cyc;
        int          k;
        exp_t        e;
        while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
        for (int l = 0; l < LANES; l++)
            d[(LANES-l)*BITS-1 -: BITS] = 8'(kidx + l) + seed;
        in_data  = d;
        in_valid = 1'b1;
        cyc = 0;
        while (!in_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        if (!in_ready) begin
            check("ready_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        for (int l = 0; l < LANES; l++) begin
            k = kidx + l;
            if (k < npx) begin
                e.x = k % cur_m;
                e.y = k / cur_m;
                e.v = 8'(k) + seed;
                mdl[e.x][e.y] = e.v;
                sb.push_back(e);
            end
        end
        kidx += LANES;
        #1;
        in_valid = 1'b0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check($sformatf("mtx[%0d][%0d]", e.x, e.y), mtx[e.x][e.y], e.v);
        end
        check("full_after_beat", full, kidx >= npx);
        @(negedge clk);
    endtask

    task automatic send_beats(input int cnt, input int gap_pct);
        for (int i = 0; i < cnt; i++) send_beat(gap_pct);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_model();
        #2;
        check("rst_busy", busy, 0);
        check("rst_ready", in_ready, 0);
        check("rst_full", full, 0);
        check("rst_err", err, 0);
        check_matrix("rst_mtx");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 4x4 fill: mtx[x][y] = x + 4y
        seed = 8'h00;
        do_start(4, 4, 1'b0);
        send_beats(4, 0);
        check("t1_ready_done", in_ready, 0);
        check("t1_busy_done", busy, 0);
        check("t1_mtx33", mtx[3][3], 8'h0F);
        check("t1_mtx12", mtx[1][2], 8'h09);
        check_matrix("t1_mtx");

        // 5x3: row wrap mid-beat, last lane discarded
        do_start(5, 3, 1'b0);
        send_beats(4, 0);
        check("t2_mtx42", mtx[4][2], 8'd14);
        check("t2_mtx03", mtx[0][3], CLEAR ? 8'h00 : 8'h0C);
        check_matrix("t2_mtx");

        // Illegal dims, and input ignored while DONE
        do_start(3, 4, 1'b0);
        in_valid = 1'b1;
        in_data  = 32'hDEAD_BEEF;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        check("t3_err_held", err, 1);
        check("t3_full", full, 0);
        check_matrix("t3_mtx");
        do_start(4, 0, 1'b0);
        do_start(33, 2, 1'b0);
        check_matrix("t3b_mtx");

        // 32x32 with random valid gaps
        seed = 8'h40;
        do_start(32, 32, 1'b0);
        send_beats(256, 50);
        check("t4_full", full, 1);
        check_matrix("t4_mtx");

        // Abort an 8x8 fill and restart 4x4 with a coincident (dropped) beat
        seed = 8'h80;
        do_start(8, 8, 1'b0);
        send_beats(2, 0);
        check("t5_busy_mid", busy, 1);
        check("t5_full_mid", full, 0);
        seed = 8'hA0;
        do_start(4, 4, 1'b1);
        send_beats(4, 0);
        check("t5_full", full, 1);
        check("t5_old_cell", mtx[5][0], CLEAR ? 8'h00 : 8'h85);
        check_matrix("t5_mtx");

        // Async reset mid-fill
        seed = 8'h10;
        do_start(8, 4, 1'b0);
        send_beats(2, 0);
        #3;
        rst_n = 1'b0;
        #1;
        clear_model();
        check("t6_busy", busy, 0);
        check("t6_ready", in_ready, 0);
        check("t6_full", full, 0);
        check("t6_err", err, 0);
        check_matrix("t6_mtx_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        seed = 8'h20;
        do_start(4, 4, 1'b0);
        send_beats(4, 0);
        check_matrix("t6_mtx_after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
